i2s_tx_sequencer: RTL and testbench

Upstream control stage for the DAC output path. It accepts stereo sample pairs over a valid/ready handshake and formats each channel into a WIDTH-bit I2S slot word. It drives the parallel word and the shift-enable of the LSB-first PISO shift register, and generates the bclk and lrclk lines to the DAC. Its bit counter tracks the PISO's internal counter, so word_out is always stable before the PISO reloads.

---
 rtl/i2s_tx_sequencer.sv | 154 +++++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_sequencer
// Purpose  : I2S transmit control stage. Accepts stereo sample pairs on a
//            valid/ready handshake, formats each channel into a WIDTH-bit
//            left-justified MSB-first slot word for an LSB-first PISO, and
//            generates shift_en, bclk and lrclk.
// Options  : I2S_TX_UNDERRUN_HOLD_EN - when defined, an underrun replays the
//            last pair; when undefined, an underrun sends silence.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_sequencer #(
  parameter int WIDTH        = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int CLK_DIV      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WIDTH-1:0]        word_out,
  output logic                    shift_en,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    underrun
);

  localparam int c_div_w = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int c_bit_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);
  localparam logic [c_bit_w-1:0] c_bit_prep = c_bit_w'(WIDTH - 2);

  // Unsupported configurations are rejected at elaboration.
  if ((SAMPLE_WIDTH > WIDTH) || (CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_cfg_bad
    $error("i2s_tx_sequencer: unsupported WIDTH/SAMPLE_WIDTH/CLK_DIV combination");
  end

  logic [c_div_w-1:0]      r_div_cnt;
  logic [c_bit_w-1:0]      r_bit_cnt;
  logic                    r_lrclk;
  logic [WIDTH-1:0]        r_word;
  logic                    r_underrun;
  logic                    r_hold_full;
  logic [SAMPLE_WIDTH-1:0] r_hold_left;
  logic [SAMPLE_WIDTH-1:0] r_hold_right;
  logic [SAMPLE_WIDTH-1:0] r_cur_right;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  // The left sample only needs to be kept when it can be replayed.
  logic [SAMPLE_WIDTH-1:0] r_cur_left;
`endif

  logic w_shift;
  logic w_prep;
  logic w_left_prep;
  logic w_right_prep;
  logic w_accept;

  // Line bit k (sent first for k=0) carries sample bit SAMPLE_WIDTH-1-k;
  // bits beyond the sample are zero padding.
  function automatic logic [WIDTH-1:0] fmt_slot(input logic [SAMPLE_WIDTH-1:0] s);
    fmt_slot = '0;
    for (int k = 0; k < SAMPLE_WIDTH; k++) begin
      fmt_slot[k] = s[SAMPLE_WIDTH-1-k];
    end
  endfunction

  assign w_shift      = rstn && (r_div_cnt == c_div_last);
  // Prep is the shift that moves into the last bit of a slot: lrclk toggles
  // one bit early and the PISO picks up the new word on the next shift.
  assign w_prep       = w_shift && (r_bit_cnt == c_bit_prep);
  assign w_left_prep  = w_prep && r_lrclk;
  assign w_right_prep = w_prep && !r_lrclk;
  assign w_accept     = s_valid && !r_hold_full;

  assign s_ready  = !r_hold_full;
  assign word_out = r_word;
  assign shift_en = w_shift;
  assign bclk     = (r_div_cnt >= c_div_half);
  assign lrclk    = r_lrclk;
  assign underrun = r_underrun;

  // Clock divider and bit counter; the bit counter mirrors the PISO counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + 1'b1;
      if (w_shift) begin
        r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

  // Slot sequencing: toggle word select and stage the next slot word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lrclk     <= 1'b0;
      r_word      <= '0;
      r_underrun  <= 1'b0;
      r_cur_right <= '0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      r_cur_left  <= '0;
`endif
    end else begin
      r_underrun <= 1'b0;
      if (w_prep) begin
        r_lrclk <= !r_lrclk;
      end
      if (w_right_prep) begin
        r_word <= fmt_slot(r_cur_right);
      end
      if (w_left_prep) begin
        if (r_hold_full) begin
          r_cur_right <= r_hold_right;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
          r_cur_left  <= r_hold_left;
`endif
          r_word      <= fmt_slot(r_hold_left);
        end else begin
          r_underrun <= 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
          r_word      <= fmt_slot(r_cur_left);
`else
          r_cur_right <= '0;
          r_word      <= '0;
`endif
        end
      end
    end
  end

  // Single-entry holding buffer between the handshake and the slot logic.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hold_full  <= 1'b0;
      r_hold_left  <= '0;
      r_hold_right <= '0;
    end else if (w_accept) begin
      r_hold_full  <= 1'b1;
      r_hold_left  <= s_left;
      r_hold_right <= s_right;
    end else if (w_left_prep) begin
      r_hold_full  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx_sequencer
// Purpose  : Self-checking bench for i2s_tx_sequencer with an LSB-first PISO
//            model on the serial side and an expected-slot scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_sequencer;

  localparam int W  = 32;
  localparam int SW = 24;
  localparam int CD = 4;

  logic          clk;
  logic          rstn;
  logic [SW-1:0] s_left;
  logic [SW-1:0] s_right;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  word_out;
  logic          shift_en;
  logic          bclk;
  logic          lrclk;
  logic          underrun;

  i2s_tx_sequencer #(.WIDTH(W), .SAMPLE_WIDTH(SW), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_left   (s_left),
    .s_right  (s_right),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .word_out (word_out),
    .shift_en (shift_en),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic [W-1:0]  wl;
    logic [W-1:0]  wr;
  } vec_t;

  typedef struct {
    logic         lr;
    logic [W-1:0] word;
    logic         un;
  } exp_t;

  vec_t tbl [4];
  exp_t expq [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // LSB-first PISO: reloads when its counter wraps, otherwise shifts right.
  logic [W-1:0] piso_q;
  int           piso_cnt;
  always @(posedge clk) begin
    if (!rstn) begin
      piso_q   <= '0;
      piso_cnt <= 0;
    end else if (shift_en) begin
      if (piso_cnt == W - 1) begin
        piso_q   <= word_out;
        piso_cnt <= 0;
      end else begin
        piso_q   <= piso_q >> 1;
        piso_cnt <= piso_cnt + 1;
      end
    end
  end
  wire serial = piso_q[0];

  // Monitor: cadence, reset values, slot scoreboard and serial capture.
  int           cyc = 0;
  int           next_prep = 31 * CD;
  int           last_prep = 0;
  logic         prev_lr = 1'b0;
  logic         prev_bclk = 1'b0;
  logic [W-1:0] cap = '0;
  int           ncap = 0;
  bit           slot_ok = 1'b0;
  logic [W-1:0] cur_w = '0;
  logic         prev_w31 = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rstn) begin
      chk("reset_values", {26'd0, word_out, lrclk, underrun, s_ready, shift_en, bclk},
          {26'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      cyc = 0;  next_prep = 31 * CD;  prev_lr = 1'b0;  prev_bclk = 1'b0;
      slot_ok = 1'b0;  ncap = 0;  cur_w = '0;  prev_w31 = 1'b0;
    end else begin
      cyc++;
      if (bclk && !prev_bclk) begin
        if (ncap < W) cap[ncap] = serial;
        ncap++;
      end
      if (lrclk != prev_lr) begin
        chk("prep_time", 64'(cyc), 64'(next_prep));
        next_prep = cyc + W * CD;
        last_prep = cyc;
        // Finished slot: filler bit from the previous word, then word bits 0..30.
        if (slot_ok) chk("serial_slot", {32'(ncap), cap}, {32'(W), cur_w[W-2:0], prev_w31});
        if (expq.size() == 0) begin
          fail_tmo("slot_unexpected");
        end else begin
          e = expq.pop_front();
          chk(lrclk ? "right_prep" : "left_prep", {30'd0, lrclk, word_out, underrun},
              {30'd0, e.lr, e.word, e.un});
        end
        if (!lrclk) chk("ready_after_left_prep", 64'(s_ready), 64'd1);
        prev_w31 = cur_w[W-1];
        cur_w    = word_out;
        slot_ok  = 1'b1;
        ncap     = 0;
      end else begin
        chk("cadence", {61'd0, shift_en, bclk, underrun},
            {61'd0, (cyc % CD) == CD - 1, (cyc % CD) >= CD / 2, 1'b0});
      end
      prev_lr   = lrclk;
      prev_bclk = bclk;
    end
  end

  task automatic send(input int i);
    int t = 0;
    s_left  = tbl[i].l;
    s_right = tbl[i].r;
    s_valid = 1'b1;
    while (!s_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      fail_tmo("accept");
    end else begin
      @(posedge clk);
      #2;
      // Each later pair is taken on the clock after the left prep that frees hold.
      if (i > 0) chk("accept_time", 64'(cyc), 64'(252 + 256 * i + 1));
      expq.push_back('{lr: 1'b0, word: tbl[i].wl, un: 1'b0});
      expq.push_back('{lr: 1'b1, word: tbl[i].wr, un: 1'b0});
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (expq.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (expq.size() != 0) fail_tmo(nm);
  endtask

  initial begin
    int t;
    rstn = 1'b0;  s_valid = 1'b0;  s_left = '0;  s_right = '0;
    tbl[0] = '{l: 24'hC00000, r: 24'h000001, wl: 32'h00000003, wr: 32'h00800000};
    tbl[1] = '{l: 24'h800000, r: 24'hFFFFFF, wl: 32'h00000001, wr: 32'h00FFFFFF};
    tbl[2] = '{l: 24'h000000, r: 24'hA5A5A5, wl: 32'h00000000, wr: 32'h00A5A5A5};
    tbl[3] = '{l: 24'h123456, r: 24'h7FFFFF, wl: 32'h006A2C48, wr: 32'h00FFFFFE};

    repeat (3) @(negedge clk);
    // Idle frame 0: zero right slot, then an underrun at the first left prep.
    expq.push_back('{lr: 1'b1, word: 32'h0, un: 1'b0});
    expq.push_back('{lr: 1'b0, word: 32'h0, un: 1'b1});
    expq.push_back('{lr: 1'b1, word: 32'h0, un: 1'b0});
    rstn = 1'b1;

    t = 0;
    while (cyc < 260 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (cyc < 260) fail_tmo("idle_frame");

    // Back-to-back pairs with s_valid held high throughout.
    for (int i = 0; i < 4; i++) send(i);
    s_valid = 1'b0;

    // Starved frame after the last pair.
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    expq.push_back('{lr: 1'b0, word: tbl[3].wl, un: 1'b1});
    expq.push_back('{lr: 1'b1, word: tbl[3].wr, un: 1'b0});
`else
    expq.push_back('{lr: 1'b0, word: 32'h0, un: 1'b1});
    expq.push_back('{lr: 1'b1, word: 32'h0, un: 1'b0});
`endif
    drain("starve_drain");

    // Mid-slot reset at right-slot bit 10.
    t = 0;
    while (!(lrclk && cyc == last_prep + CD + 10 * CD) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!(lrclk && cyc == last_prep + CD + 10 * CD)) fail_tmo("reset_point");
    expq.delete();
    expq.push_back('{lr: 1'b1, word: 32'h0, un: 1'b0});
    expq.push_back('{lr: 1'b0, word: 32'h0, un: 1'b1});
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    drain("post_reset_drain");

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
